// File: rtl/simd_fetch_pkg.sv
// simd_fetch_pkg: shared state encoding, default halt opcode and matrix shape types
// for the SIMD fetch/operand unit.
package simd_fetch_pkg;
    localparam int unsigned PKG_N = 2;
    localparam int unsigned PKG_W = 32;
    localparam logic [31:0] DEFAULT_HALT_OP = 32'h0000_0000;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_B,
        ST_LOAD_A,
        ST_FETCH,
        ST_CAPTURE,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;
    typedef logic [PKG_N*PKG_W-1:0] row_t;
    typedef logic [PKG_N*PKG_N*PKG_W-1:0] mat_t;
endpackage

// File: rtl/simd_matrix_loader.sv
// simd_matrix_loader: accepts one matrix row per valid/ready handshake into an NxN
// register array, optionally writing each row as a column instead.
module simd_matrix_loader
    import simd_fetch_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 32,
    localparam int unsigned SW = N > 1 ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             transpose_i,
    input  logic             valid_i,
    input  logic [N*W-1:0]   row_i,
    output logic             ready_o,
    output logic             last_o,
    output logic [SW-1:0]    seq_o,
    output logic [N*N*W-1:0] mat_o
);
    logic [SW-1:0] seq_q, seq_d;
    logic [N*N*W-1:0] mat_q, mat_d;
    logic accept;

    assign accept = active_i && valid_i;
    assign ready_o = active_i;
    assign last_o = accept && seq_q == SW'(N-1);
    assign seq_o = seq_q;
    assign mat_o = mat_q;

    // Transposed: element (r,c) of column seq takes incoming element r.
    always_comb begin
        seq_d = accept ? (last_o ? '0 : seq_q + 1'b1) : seq_q;
        mat_d = mat_q;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (accept && (transpose_i ? SW'(c) == seq_q : SW'(r) == seq_q))
                    mat_d[(r*N+c)*W +: W] = row_i[(transpose_i ? r : c)*W +: W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q <= '0;
            mat_q <= '0;
        end else begin
            seq_q <= seq_d;
            mat_q <= mat_d;
        end
    end
endmodule

// File: rtl/simd_fetch_unit.sv
// simd_fetch_unit: loads matrices B then A, then runs a fetch/capture/execute loop
// against instruction memory until the halt opcode is fetched.
module simd_fetch_unit
    import simd_fetch_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 32,
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned ADDR = 0,
    parameter logic [31:0] HALT_OP = DEFAULT_HALT_OP,
    localparam int unsigned PCW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1,
    localparam int unsigned SW = N > 1 ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             TRANSPOSE_B,
    input  logic [N*W-1:0]   MAT_IN,
    input  logic             MAT_VALID,
    output logic             MAT_READY,
    output logic [SW-1:0]    SEQ,
    output logic             LOAD_DONE,
    output logic [N*N*W-1:0] MAT_A_OUT,
    output logic [N*N*W-1:0] MAT_B_OUT,
    output logic [PCW-1:0]   PC_INS,
    input  logic [31:0]      INSTRDATA,
    output logic [31:0]      INSTR,
    output logic             INSTR_VALID,
    input  logic             DONE,
    input  logic [W-1:0]     DATAOUT,
    output logic [W-1:0]     RESULT,
    output logic             RESULT_VALID,
    output logic             HALTED
);
    fetch_state_t state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d, pc_ins_q;
    logic [31:0] instr_q;
    logic [W-1:0] result_q;
    logic [SW-1:0] seq_b, seq_a;
    logic tr_q, load_done_q, instr_valid_q, result_valid_q;
    logic rdy_b, rdy_a, last_b, last_a, start_ok, take_instr, take_result;

    assign start_ok = START && (state_q == ST_IDLE || state_q == ST_HALT);
    assign take_instr = state_q == ST_CAPTURE && INSTRDATA != HALT_OP;
    assign take_result = state_q == ST_EXEC && DONE;

    simd_matrix_loader #(.N(N), .W(W)) u_load_b (
        .clk_i(CLK), .rst_i(RSTN), .active_i(state_q == ST_LOAD_B), .transpose_i(tr_q),
        .valid_i(MAT_VALID), .row_i(MAT_IN), .ready_o(rdy_b), .last_o(last_b),
        .seq_o(seq_b), .mat_o(MAT_B_OUT)
    );

    simd_matrix_loader #(.N(N), .W(W)) u_load_a (
        .clk_i(CLK), .rst_i(RSTN), .active_i(state_q == ST_LOAD_A), .transpose_i(1'b0),
        .valid_i(MAT_VALID), .row_i(MAT_IN), .ready_o(rdy_a), .last_o(last_a),
        .seq_o(seq_a), .mat_o(MAT_A_OUT)
    );

    assign MAT_READY = rdy_b || rdy_a;
    assign SEQ = state_q == ST_LOAD_A ? seq_a : seq_b;
    assign LOAD_DONE = load_done_q;
    assign PC_INS = pc_ins_q;
    assign INSTR = instr_q;
    assign INSTR_VALID = instr_valid_q;
    assign RESULT = result_q;
    assign RESULT_VALID = result_valid_q;
    assign HALTED = state_q == ST_HALT;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        case (state_q)
            ST_IDLE:    if (START) state_d = ST_LOAD_B;
            ST_LOAD_B:  if (last_b) state_d = ST_LOAD_A;
            ST_LOAD_A:  if (last_a) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = take_instr ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                if (DONE) begin
                    state_d = ST_FETCH;
                    pc_d = pc_q == PCW'(IMEM_DEPTH-1) ? '0 : pc_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (START) begin
                    state_d = ST_LOAD_B;
                    pc_d = PCW'(ADDR);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The address register only moves when entering FETCH, so it holds elsewhere.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state_q <= ST_IDLE;
            pc_q <= PCW'(ADDR);
            pc_ins_q <= PCW'(ADDR);
            tr_q <= 1'b0;
            load_done_q <= 1'b0;
            instr_q <= '0;
            instr_valid_q <= 1'b0;
            result_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            if (state_d == ST_FETCH) pc_ins_q <= pc_d;
            if (start_ok) tr_q <= TRANSPOSE_B;
            load_done_q <= last_a;
            instr_valid_q <= take_instr;
            if (take_instr) instr_q <= INSTRDATA;
            result_valid_q <= take_result;
            if (take_result) result_q <= DATAOUT;
        end
    end
endmodule

// File: tb/tb_simd_fetch_unit.sv
// tb_simd_fetch_unit: directed-sequence bench with randomized rows, instructions and
// results, checked against a plain array model of the matrices and program counter.
module tb_simd_fetch_unit;
    localparam int N = 2;
    localparam int W = 32;
    localparam int DEPTH = 4;
    localparam int ADDR = 1;
    localparam int PCW = 2;
    localparam logic [31:0] HALT_OP = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    logic START = 1'b0;
    logic TRANSPOSE_B = 1'b0;
    logic MAT_VALID = 1'b0;
    logic DONE = 1'b0;
    logic [N*W-1:0] MAT_IN = '0;
    logic [W-1:0] DATAOUT = '0;
    logic [31:0] INSTRDATA = '0;
    logic MAT_READY, LOAD_DONE, INSTR_VALID, RESULT_VALID, HALTED;
    logic [0:0] SEQ;
    logic [N*N*W-1:0] MAT_A_OUT, MAT_B_OUT;
    logic [PCW-1:0] PC_INS;
    logic [31:0] INSTR;
    logic [W-1:0] RESULT;

    int checks = 0;
    int failures = 0;
    logic [31:0] imem [DEPTH];
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    logic [W-1:0] exp_result = '0;
    int pc = ADDR;

    simd_fetch_unit #(
        .N(N), .W(W), .IMEM_DEPTH(DEPTH), .ADDR(ADDR), .HALT_OP(HALT_OP)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .TRANSPOSE_B(TRANSPOSE_B),
        .MAT_IN(MAT_IN), .MAT_VALID(MAT_VALID), .MAT_READY(MAT_READY), .SEQ(SEQ),
        .LOAD_DONE(LOAD_DONE), .MAT_A_OUT(MAT_A_OUT), .MAT_B_OUT(MAT_B_OUT),
        .PC_INS(PC_INS), .INSTRDATA(INSTRDATA), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .DONE(DONE), .DATAOUT(DATAOUT), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
        .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    // Synchronous instruction memory: one cycle read latency.
    always @(posedge CLK) INSTRDATA <= imem[PC_INS];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [N*N*W-1:0] obs, input logic [N*N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N*N*W-1:0] pack(input bit sel_a);
        logic [N*N*W-1:0] v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[(r*N+c)*W +: W] = sel_a ? ma[r][c] : mb[r][c];
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        pc = ADDR;
        exp_result = '0;
    endtask

    task automatic chk_reset();
        chk("rst_mat_ready", MAT_READY, 0);
        chk("rst_seq", SEQ, 0);
        chk("rst_load_done", LOAD_DONE, 0);
        chk("rst_mat_a", MAT_A_OUT, 0);
        chk("rst_mat_b", MAT_B_OUT, 0);
        chk("rst_pc_ins", PC_INS, ADDR);
        chk("rst_instr", INSTR, 0);
        chk("rst_instr_valid", INSTR_VALID, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_result_valid", RESULT_VALID, 0);
        chk("rst_halted", HALTED, 0);
    endtask

    // Streams B then A; directed uses B rows [1,2],[3,4] and A rows [4,5],[7,8].
    task automatic load(input bit tr, input bit directed, input bit stall);
        logic [W-1:0] e;
        START = 1'b1;
        TRANSPOSE_B = tr;
        tick();
        START = 1'b0;
        TRANSPOSE_B = ~tr;
        chk("load_ready_b", MAT_READY, 1);
        chk("load_not_halted", HALTED, 0);
        for (int ph = 0; ph < 2; ph++)
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    e = directed ? W'(ph == 0 ? r*2 + c + 1 : r*3 + c + 4) : W'($urandom);
                    MAT_IN[c*W +: W] = e;
                    if (ph == 1) ma[r][c] = e;
                    else if (tr) mb[c][r] = e;
                    else mb[r][c] = e;
                end
                for (int s = stall ? 1 + $urandom_range(1, 0) : 0; s > 0; s--) begin
                    MAT_VALID = 1'b0;
                    chk("seq_stall", SEQ, r);
                    chk("ready_stall", MAT_READY, 1);
                    tick();
                end
                MAT_VALID = 1'b1;
                chk("seq", SEQ, r);
                chk("ready", MAT_READY, 1);
                chk("load_done_low", LOAD_DONE, 0);
                tick();
                MAT_VALID = 1'b0;
            end
        chk("load_done_pulse", LOAD_DONE, 1);
        chk("mat_b", MAT_B_OUT, pack(1'b0));
        chk("mat_a", MAT_A_OUT, pack(1'b1));
        chk("ready_after_load", MAT_READY, 0);
    endtask

    // Starts in FETCH; executes until the halt opcode is fetched.
    task automatic run_prog();
        bit halted = 1'b0;
        for (int n = 0; n < 16 && !halted; n++) begin
            chk("pc_ins_fetch", PC_INS, pc);
            DONE = 1'b1;
            DATAOUT = W'(32'hdead_beef);
            tick();
            chk("pc_ins_capture", PC_INS, pc);
            chk("no_result_capture", RESULT_VALID, 0);
            tick();
            DONE = 1'b0;
            chk("no_result_exec_entry", RESULT_VALID, 0);
            if (imem[pc] == HALT_OP) begin
                halted = 1'b1;
                chk("halted", HALTED, 1);
                chk("halt_no_instr_valid", INSTR_VALID, 0);
            end else begin
                chk("instr_valid", INSTR_VALID, 1);
                chk("instr", INSTR, imem[pc]);
                for (int d = $urandom_range(3, 0); d > 0; d--) begin
                    START = 1'b1;
                    MAT_VALID = 1'b1;
                    tick();
                    START = 1'b0;
                    MAT_VALID = 1'b0;
                    chk("instr_valid_once", INSTR_VALID, 0);
                    chk("ready_exec", MAT_READY, 0);
                    chk("result_wait", RESULT_VALID, 0);
                end
                exp_result = W'($urandom);
                DONE = 1'b1;
                DATAOUT = exp_result;
                tick();
                DONE = 1'b0;
                chk("result_valid", RESULT_VALID, 1);
                chk("result", RESULT, exp_result);
                pc = (pc + 1) % DEPTH;
            end
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic chk_halt_hold();
        DONE = 1'b1;
        DATAOUT = '1;
        repeat (3) tick();
        DONE = 1'b0;
        chk("halt_hold", HALTED, 1);
        chk("halt_no_result_valid", RESULT_VALID, 0);
        chk("halt_result_hold", RESULT, exp_result);
        chk("halt_pc_hold", PC_INS, pc);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) imem[i] = $urandom | 32'h1;
        imem[0] = HALT_OP;
        clear_model();
        RSTN = 1'b1;
        tick();
        tick();
        RSTN = 1'b0;
        chk_reset();
        MAT_VALID = 1'b1;
        DONE = 1'b1;
        tick();
        MAT_VALID = 1'b0;
        DONE = 1'b0;
        chk("idle_ready", MAT_READY, 0);
        chk("idle_result_valid", RESULT_VALID, 0);

        // Directed load, then run 1,2,3 and wrap to the halt at address 0.
        load(1'b0, 1'b1, 1'b0);
        chk("load_done_once", LOAD_DONE, 1);
        run_prog();
        chk("wrap_pc", PC_INS, 0);
        chk_halt_hold();

        // Restart from HALT with transposed B and stalls.
        for (int i = 0; i < DEPTH; i++) imem[i] = $urandom | 32'h1;
        imem[2] = HALT_OP;
        pc = ADDR;
        load(1'b1, 1'b1, 1'b1);
        run_prog();
        chk_halt_hold();

        // Reset in the middle of loading A.
        START = 1'b1;
        tick();
        START = 1'b0;
        MAT_VALID = 1'b1;
        MAT_IN = {W'($urandom), W'($urandom)};
        repeat (N + 1) tick();
        MAT_VALID = 1'b0;
        chk("mid_a_ready", MAT_READY, 1);
        chk("mid_a_seq", SEQ, 1);
        RSTN = 1'b1;
        tick();
        RSTN = 1'b0;
        clear_model();
        chk_reset();

        // Random load and program after reset.
        load(1'b0, 1'b0, 1'b1);
        run_prog();
        chk_halt_hold();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simd_fetch_unit.md
Name: simd_fetch_unit

Overview:
Next-generation fetch/operand unit for the SIMD matrix processor. Streams matrix B, then matrix A, into internal NxN register arrays one row per handshake, with optional transpose of B on load. It then runs a fetch/execute/writeback loop against instruction memory, with halt detection and a programmable start PC. It sits between external memory/host and the execute array, and generalises the earlier fixed-width, fixed-order fetch unit.

Parameters:
N, 2, matrix dimension (rows = cols); N >= 1
W, 32, element width in bits
IMEM_DEPTH, 512, instruction memory depth in words; PC width PCW = $clog2(IMEM_DEPTH)
ADDR, 0, reset/restart PC value; must be < IMEM_DEPTH
HALT_OP, 32'h0000_0000, instruction word that halts the unit

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  reset, synchronous, active-high (1 = reset)
START  in  1  one-cycle pulse; starts load sequence from IDLE or HALT
TRANSPOSE_B  in  1  sampled on the accepted START; 1 = store B rows as columns
MAT_IN  in  N*W  one matrix row; element j at bits [j*W +: W]
MAT_VALID  in  1  MAT_IN valid
MAT_READY  out  1  unit accepts a row this cycle
SEQ  out  $clog2(N) (min 1)  current row index being loaded
LOAD_DONE  out  1  one-cycle pulse after the last row of A is accepted
MAT_A_OUT  out  N*N*W  matrix A, row-major
MAT_B_OUT  out  N*N*W  matrix B, row-major (post-transpose)
PC_INS  out  PCW  instruction address
INSTRDATA  in  32  instruction memory data, 1-cycle read latency
INSTR  out  32  fetched instruction
INSTR_VALID  out  1  one-cycle pulse, INSTR is new
DONE  in  1  execute complete; DATAOUT valid
DATAOUT  in  W  execute result
RESULT  out  W  registered result
RESULT_VALID  out  1  one-cycle pulse, RESULT is new
HALTED  out  1  high while in HALT

Behaviour:
- Reset (RSTN=1 at CLK edge, any state): state=IDLE, PC=ADDR, SEQ=0, matrices=0, INSTR=0, RESULT=0. All valid/ready/pulse outputs and HALTED are 0. Reset overrides every other input in the same cycle.
- States: IDLE, LOAD_B, LOAD_A, FETCH, CAPTURE, EXEC, HALT.
- IDLE: MAT_READY=0. START -> LOAD_B, SEQ=0, latch TRANSPOSE_B.
- LOAD_B: MAT_READY=1. On MAT_VALID&MAT_READY, write row SEQ, or column SEQ if transposed, then SEQ++. The accept at SEQ==N-1 goes to LOAD_A with SEQ=0. MAT_VALID=0 stalls indefinitely.
- LOAD_A: same handshake, never transposed. The last accept goes to FETCH and LOAD_DONE pulses in the next cycle.
- FETCH: PC_INS=PC for one cycle -> CAPTURE.
- CAPTURE: sample INSTRDATA. If it equals HALT_OP -> HALT, no INSTR_VALID, PC unchanged. Otherwise INSTR<=INSTRDATA, INSTR_VALID pulses one cycle -> EXEC.
- EXEC: wait for DONE. On DONE: RESULT<=DATAOUT, RESULT_VALID pulses the next cycle, PC<=PC+1 (wraps IMEM_DEPTH-1 -> 0) -> FETCH. Minimum loop is 3 cycles per instruction.
- HALT: HALTED=1, PC_INS holds PC. START -> PC=ADDR, LOAD_B (full reload).
- Ignored inputs: START outside IDLE/HALT; MAT_VALID outside the LOAD states (MAT_READY=0); DONE outside EXEC.
- PC_INS holds its last value outside FETCH/CAPTURE.
- MAT_A_OUT and MAT_B_OUT are registered and hold until overwritten or reset. Partially loaded contents are visible during a load.
- N=1: a single accept completes each load phase; SEQ stays 0.

Decomposition:
- Package simd_fetch_pkg: state enum fetch_state_t, default HALT_OP constant, row/matrix packed typedefs parameterised via N and W localparams.
- One natural sub-module: simd_matrix_loader. It holds the row counter, handshake and transpose write logic, and is instantiated once for B (transpose enabled) and once for A. The FSM and PC logic stay in the top.

Test Plan:
- Reset: RSTN=1 mid-LOAD_A (N=2, W=32) -> next cycle all outputs 0, PC_INS=ADDR, MAT_READY=0, matrices cleared.
- Load no transpose: START, TRANSPOSE_B=0; rows B {2,1},{4,3}, A {5,4},{8,7} -> MAT_B_OUT rows [1,2],[3,4]; MAT_A_OUT rows [4,5],[7,8]; LOAD_DONE pulses once, one cycle after the 4th accept.
- Load with transpose and stalls: TRANSPOSE_B=1, MAT_VALID toggled 1/0 -> same B rows stored as columns, giving B rows [1,3],[2,4]. SEQ advances only on accept.
- Fetch/execute: INSTRDATA=5 at PC 0, DONE after 4 cycles with DATAOUT=45 -> INSTR=5 with one INSTR_VALID pulse; RESULT=45 with one RESULT_VALID pulse; PC_INS=1 on the next FETCH.
- PC wrap: IMEM_DEPTH=4, ADDR=3, non-halt instruction -> after DONE, PC_INS=0.
- Halt/restart: INSTRDATA=HALT_OP -> HALTED=1, no INSTR_VALID, DONE ignored. START -> HALTED=0, PC=ADDR, MAT_READY=1 in LOAD_B.
